// File: rtl/vcu_pkg.sv
// Shared types for the vector control unit: opcode classes, FSM states and the
// bundled decode control word.
package vcu_pkg;

    typedef enum logic [2:0] {
        OP_ALU  = 3'b000,
        OP_ALUI = 3'b001,
        OP_LDR  = 3'b010,
        OP_STR  = 3'b011,
        OP_B    = 3'b100,
        OP_VALU = 3'b101,
        OP_VLDR = 3'b110,
        OP_VSTR = 3'b111
    } opcode_e;

    typedef enum logic {
        IDLE = 1'b0,
        VRUN = 1'b1
    } vcu_state_e;

    localparam logic [1:0] IMM_DP     = 2'b00;
    localparam logic [1:0] IMM_MEM    = 2'b01;
    localparam logic [1:0] IMM_BR     = 2'b10;
    localparam logic [1:0] REGSRC_DP  = 2'b00;
    localparam logic [1:0] REGSRC_BR  = 2'b01;
    localparam logic [1:0] REGSRC_STR = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic [2:0] alu_control;
        logic       alu_sel;
        logic       branch;
        logic       alu_src;
        logic [1:0] flag_write;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    function automatic logic is_vector(opcode_e op);
        return op inside {OP_VALU, OP_VLDR, OP_VSTR};
    endfunction

endpackage

// File: rtl/vcu_decoder.sv
// Purely combinational Opcode/Func -> control-word decode, shared by the live
// and the latched (in-flight vector) instruction paths.
module vcu_decoder
    import vcu_pkg::*;
(
    input  opcode_e    opcode,
    input  logic [2:0] func,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = CTRL_NONE;
        case (opcode)
            OP_ALU, OP_VALU: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_control = func;
                ctrl.flag_write  = 2'b11;
            end
            OP_ALUI: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_control = func;
                ctrl.flag_write  = 2'b11;
                ctrl.alu_src     = 1'b1;
                ctrl.imm_src     = IMM_DP;
            end
            OP_LDR, OP_VLDR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.imm_src    = IMM_MEM;
            end
            OP_STR, OP_VSTR: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_MEM;
                ctrl.reg_src   = REGSRC_STR;
            end
            OP_B: begin
                ctrl.branch  = 1'b1;
                ctrl.alu_src = 1'b1;
                ctrl.imm_src = IMM_BR;
                ctrl.reg_src = REGSRC_BR;
            end
            default: ctrl = CTRL_NONE;
        endcase
        // Vector classes reuse the scalar decode but run on the lane ALU and never touch flags.
        if (is_vector(opcode)) begin
            ctrl.alu_sel    = 1'b1;
            ctrl.flag_write = 2'b00;
        end
    end

endmodule

// File: rtl/vector_control_unit.sv
// Decode-stage control unit that sequences vector ops over VLEN/LANE_W chunks.
// Optional macro VCU_PERF_CNT_EN adds StallCycles/VecInstrs performance counters.
module vector_control_unit
    import vcu_pkg::*;
#(
    parameter  int VLEN   = 128,
    parameter  int LANE_W = 32,
    parameter  int RD_W   = 4,
    parameter  int PC_REG = 15,
    localparam int CHUNKS = VLEN / LANE_W,
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            InstrValid,
    input  logic [2:0]      Opcode,
    input  logic [2:0]      Func,
    input  logic [RD_W-1:0] Rd,
    input  logic            Hold,
    input  logic            Flush,
    output logic            PCSrc,
    output logic            RegWrite,
    output logic            MemtoReg,
    output logic            MemWrite,
    output logic [2:0]      ALUControl,
    output logic            ALUSel,
    output logic            Branch,
    output logic            ALUSrc,
    output logic [1:0]      FlagWrite,
    output logic [1:0]      ImmSrc,
    output logic [1:0]      RegSrc,
    output logic [CW-1:0]   ChunkIdx,
    output logic            Stuck,
    output vcu_state_e      dbg_state
`ifdef VCU_PERF_CNT_EN
    ,
    output logic [31:0]     StallCycles,
    output logic [31:0]     VecInstrs
`endif
);

    if (VLEN % LANE_W != 0) begin : g_bad_cfg
        $error("vector_control_unit: VLEN must be a multiple of LANE_W");
    end

    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    vcu_state_e      state, state_next;
    logic [CW-1:0]   chunk, chunk_next;
    opcode_e         op_q;
    logic [2:0]      func_q;
    logic [RD_W-1:0] rd_q;
    logic            latch_en;

    opcode_e         op_sel;
    logic [2:0]      func_sel;
    logic [RD_W-1:0] rd_sel;
    ctrl_t           dec;
    ctrl_t           ctrl;
    logic            live_vec, entry, last_chunk, active;

    // While a vector op is in flight the decoder sees the latched instruction, not decode.
    assign op_sel     = (state == VRUN) ? op_q   : opcode_e'(Opcode);
    assign func_sel   = (state == VRUN) ? func_q : Func;
    assign rd_sel     = (state == VRUN) ? rd_q   : Rd;
    assign active     = (state == VRUN) || InstrValid;
    assign live_vec   = InstrValid && is_vector(opcode_e'(Opcode));
    assign entry      = (state == IDLE) && live_vec && (CHUNKS > 1) && !Flush;
    assign last_chunk = (chunk == LAST);

    vcu_decoder u_decoder (
        .opcode (op_sel),
        .func   (func_sel),
        .ctrl   (dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            chunk  <= '0;
            op_q   <= OP_ALU;
            func_q <= '0;
            rd_q   <= '0;
        end else begin
            state <= state_next;
            chunk <= chunk_next;
            if (latch_en) begin
                op_q   <= opcode_e'(Opcode);
                func_q <= Func;
                rd_q   <= Rd;
            end
        end
    end

    always_comb begin
        state_next = state;
        chunk_next = chunk;
        latch_en   = 1'b0;
        case (state)
            IDLE: begin
                if (entry && !Hold) begin
                    state_next = VRUN;
                    chunk_next = CW'(1);
                    latch_en   = 1'b1;
                end
            end
            VRUN: begin
                if (Flush) begin
                    state_next = IDLE;
                    chunk_next = '0;
                end else if (!Hold) begin
                    if (last_chunk) begin
                        state_next = IDLE;
                        chunk_next = '0;
                    end else begin
                        chunk_next = chunk + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                chunk_next = '0;
            end
        endcase
    end

    always_comb begin
        ctrl       = active ? dec : CTRL_NONE;
        RegWrite   = ctrl.reg_write && !Hold && !Flush;
        MemWrite   = ctrl.mem_write && !Hold && !Flush;
        MemtoReg   = ctrl.mem_to_reg;
        ALUControl = ctrl.alu_control;
        ALUSel     = ctrl.alu_sel;
        Branch     = ctrl.branch;
        ALUSrc     = ctrl.alu_src;
        FlagWrite  = ctrl.flag_write;
        ImmSrc     = ctrl.imm_src;
        RegSrc     = ctrl.reg_src;
        // The redirect is judged on the decoded write, so a held PC write still redirects.
        PCSrc      = !ctrl.alu_sel && !Flush &&
                     (ctrl.branch || (ctrl.reg_write && rd_sel == RD_W'(PC_REG)));
        ChunkIdx   = chunk;
        Stuck      = entry || ((state == VRUN) && (!last_chunk || Hold));
        dbg_state  = state;
    end

`ifdef VCU_PERF_CNT_EN
    logic vec_done;
    assign vec_done = !Flush && !Hold &&
                      (((state == VRUN) && last_chunk) || ((CHUNKS == 1) && live_vec));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCycles <= '0;
            VecInstrs   <= '0;
        end else begin
            if (Stuck)    StallCycles <= StallCycles + 32'd1;
            if (vec_done) VecInstrs   <= VecInstrs + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vector_control_unit.sv
// Bench for vector_control_unit: decode table, multi-cycle vector sequences,
// a CHUNKS=1 instance, and random stimulus against a behavioural model.
`timescale 1ns/1ps
module tb_vector_control_unit;
    import vcu_pkg::*;

    localparam int CHUNKS = 128 / 32;

    typedef struct packed {
        logic       pcsrc;
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic [2:0] aluctl;
        logic       alusel;
        logic       branch;
        logic       alusrc;
        logic [1:0] flagwrite;
        logic [1:0] immsrc;
        logic [1:0] regsrc;
        logic [1:0] chunk;
        logic       stuck;
    } out_t;

    typedef struct {
        logic       valid;
        logic [2:0] op;
        logic [2:0] func;
        logic [3:0] rd;
        logic       hold;
        logic       flush;
        out_t       exp;
        string      name;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       InstrValid = 1'b0;
    logic [2:0] Opcode = '0;
    logic [2:0] Func = '0;
    logic [3:0] Rd = '0;
    logic       Hold = 1'b0;
    logic       Flush = 1'b0;

    logic       PCSrc, RegWrite, MemtoReg, MemWrite, ALUSel, Branch, ALUSrc, Stuck;
    logic [2:0] ALUControl;
    logic [1:0] FlagWrite, ImmSrc, RegSrc, ChunkIdx;
    vcu_state_e dbg_state;

    logic       PCSrc1, RegWrite1, MemtoReg1, MemWrite1, ALUSel1, Branch1, ALUSrc1, Stuck1;
    logic [2:0] ALUControl1;
    logic [1:0] FlagWrite1, ImmSrc1, RegSrc1;
    logic [0:0] ChunkIdx1;
    vcu_state_e dbg_state1;

`ifdef VCU_PERF_CNT_EN
    logic [31:0] StallCycles, VecInstrs, StallCycles1, VecInstrs1;
`endif

    vector_control_unit u_dut (
        .clk(clk), .rst_n(rst_n), .InstrValid(InstrValid), .Opcode(Opcode), .Func(Func),
        .Rd(Rd), .Hold(Hold), .Flush(Flush), .PCSrc(PCSrc), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUControl(ALUControl), .ALUSel(ALUSel),
        .Branch(Branch), .ALUSrc(ALUSrc), .FlagWrite(FlagWrite), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .ChunkIdx(ChunkIdx), .Stuck(Stuck), .dbg_state(dbg_state)
`ifdef VCU_PERF_CNT_EN
        , .StallCycles(StallCycles), .VecInstrs(VecInstrs)
`endif
    );

    vector_control_unit #(.LANE_W(128)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .InstrValid(InstrValid), .Opcode(Opcode), .Func(Func),
        .Rd(Rd), .Hold(Hold), .Flush(Flush), .PCSrc(PCSrc1), .RegWrite(RegWrite1),
        .MemtoReg(MemtoReg1), .MemWrite(MemWrite1), .ALUControl(ALUControl1), .ALUSel(ALUSel1),
        .Branch(Branch1), .ALUSrc(ALUSrc1), .FlagWrite(FlagWrite1), .ImmSrc(ImmSrc1),
        .RegSrc(RegSrc1), .ChunkIdx(ChunkIdx1), .Stuck(Stuck1), .dbg_state(dbg_state1)
`ifdef VCU_PERF_CNT_EN
        , .StallCycles(StallCycles1), .VecInstrs(VecInstrs1)
`endif
    );

    out_t act0, act1;
    assign act0 = {PCSrc, RegWrite, MemtoReg, MemWrite, ALUControl, ALUSel, Branch, ALUSrc,
                   FlagWrite, ImmSrc, RegSrc, ChunkIdx, Stuck};
    assign act1 = {PCSrc1, RegWrite1, MemtoReg1, MemWrite1, ALUControl1, ALUSel1, Branch1,
                   ALUSrc1, FlagWrite1, ImmSrc1, RegSrc1, 1'b0, ChunkIdx1, Stuck1};

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input out_t got, input out_t exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    function automatic out_t mk(input logic pc, rw, m2r, mw, input logic [2:0] alu,
                                input logic vs, br, src, input logic [1:0] fw, imm, rs, ch,
                                input logic st);
        return {pc, rw, m2r, mw, alu, vs, br, src, fw, imm, rs, ch, st};
    endfunction

    // ---------------- reference model ----------------
    // Pending vector work is a count of chunks still to issue; issued index = CHUNKS - remaining.
    int         remaining = 0;
    logic [2:0] l_op = '0;
    logic [2:0] l_func = '0;

    function automatic out_t decode_ref(input logic [2:0] op, input logic [2:0] func);
        out_t e = '0;
        case (op)
            3'd0, 3'd5: begin e.regwrite = 1; e.aluctl = func; e.flagwrite = 2'b11; end
            3'd1: begin e.regwrite = 1; e.aluctl = func; e.flagwrite = 2'b11; e.alusrc = 1; end
            3'd2, 3'd6: begin e.regwrite = 1; e.memtoreg = 1; e.alusrc = 1; e.immsrc = 2'b01; end
            3'd3, 3'd7: begin e.memwrite = 1; e.alusrc = 1; e.immsrc = 2'b01; e.regsrc = 2'b10; end
            default: begin e.branch = 1; e.alusrc = 1; e.immsrc = 2'b10; e.regsrc = 2'b01; end
        endcase
        if (op >= 3'd5) begin
            e.alusel = 1;
            e.flagwrite = 2'b00;
        end
        return e;
    endfunction

    function automatic out_t model_expect();
        out_t e;
        logic vec;
        if (remaining == 0) begin
            e = InstrValid ? decode_ref(Opcode, Func) : '0;
            vec = InstrValid && (Opcode >= 3'd5);
            e.pcsrc = InstrValid && !vec && !Flush && (e.branch || (e.regwrite && Rd == 4'd15));
            e.stuck = vec && (CHUNKS > 1) && !Flush;
            e.chunk = 2'd0;
        end else begin
            e = decode_ref(l_op, l_func);
            e.chunk = 2'(CHUNKS - remaining);
            e.stuck = (remaining != 1) || Hold;
        end
        if (Hold || Flush) begin
            e.regwrite = 0;
            e.memwrite = 0;
        end
        return e;
    endfunction

    task automatic model_step();
        if (remaining == 0) begin
            if (InstrValid && Opcode >= 3'd5 && CHUNKS > 1 && !Flush && !Hold) begin
                remaining = CHUNKS - 1;
                l_op = Opcode;
                l_func = Func;
            end
        end else if (Flush) begin
            remaining = 0;
        end else if (!Hold) begin
            remaining--;
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [2:0] op, func, input logic [3:0] rd,
                         input logic h, f);
        InstrValid = v; Opcode = op; Func = func; Rd = rd; Hold = h; Flush = f;
    endtask

    task automatic apply(input logic v, input logic [2:0] op, func, input logic [3:0] rd,
                         input logic h, f, input out_t exp, input string name);
        drive(v, op, func, rd, h, f);
        @(negedge clk);
        check(name, act0, exp);
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[$];

    initial begin
        // Reset state with no instruction presented.
        #12;
        check("reset_outputs", act0, '0);
        check_val("reset_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-cycle scalar decode, Hold/Flush gating, and IDLE-entry suppression.
        tbl.push_back('{0, 3'd0, 3'd5, 4'd15, 0, 0, mk(0,0,0,0,3'd0,0,0,0,0,0,0,0,0), "invalid"});
        tbl.push_back('{1, 3'd0, 3'd5, 4'd3,  0, 0, mk(0,1,0,0,3'd5,0,0,0,3,0,0,0,0), "alu"});
        tbl.push_back('{1, 3'd0, 3'd2, 4'd15, 0, 0, mk(1,1,0,0,3'd2,0,0,0,3,0,0,0,0), "alu_rd15"});
        tbl.push_back('{1, 3'd1, 3'd6, 4'd2,  0, 0, mk(0,1,0,0,3'd6,0,0,1,3,0,0,0,0), "alui"});
        tbl.push_back('{1, 3'd2, 3'd7, 4'd4,  0, 0, mk(0,1,1,0,3'd0,0,0,1,0,1,0,0,0), "ldr"});
        tbl.push_back('{1, 3'd2, 3'd0, 4'd15, 0, 0, mk(1,1,1,0,3'd0,0,0,1,0,1,0,0,0), "ldr_rd15"});
        tbl.push_back('{1, 3'd3, 3'd3, 4'd15, 0, 0, mk(0,0,0,1,3'd0,0,0,1,0,1,2,0,0), "str"});
        tbl.push_back('{1, 3'd4, 3'd4, 4'd0,  0, 0, mk(1,0,0,0,3'd0,0,1,1,0,2,1,0,0), "b"});
        tbl.push_back('{1, 3'd0, 3'd1, 4'd5,  1, 0, mk(0,0,0,0,3'd1,0,0,0,3,0,0,0,0), "alu_hold"});
        tbl.push_back('{1, 3'd3, 3'd0, 4'd2,  1, 0, mk(0,0,0,0,3'd0,0,0,1,0,1,2,0,0), "str_hold"});
        tbl.push_back('{1, 3'd3, 3'd0, 4'd1,  0, 1, mk(0,0,0,0,3'd0,0,0,1,0,1,2,0,0), "str_flush"});
        tbl.push_back('{1, 3'd4, 3'd0, 4'd0,  0, 1, mk(0,0,0,0,3'd0,0,1,1,0,2,1,0,0), "b_flush"});
        tbl.push_back('{1, 3'd0, 3'd4, 4'd15, 0, 1, mk(0,0,0,0,3'd4,0,0,0,3,0,0,0,0), "alu_flush"});
        tbl.push_back('{0, 3'd5, 3'd1, 4'd1,  0, 0, mk(0,0,0,0,3'd0,0,0,0,0,0,0,0,0), "valu_invalid"});
        tbl.push_back('{1, 3'd5, 3'd2, 4'd15, 0, 1, mk(0,0,0,0,3'd2,1,0,0,0,0,0,0,0), "valu_flush_idle"});
        tbl.push_back('{0, 3'd0, 3'd0, 4'd0,  0, 0, mk(0,0,0,0,3'd0,0,0,0,0,0,0,0,0), "idle_after_flush"});
        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i].valid, tbl[i].op, tbl[i].func, tbl[i].rd, tbl[i].hold, tbl[i].flush,
                  tbl[i].exp, tbl[i].name);

        // Asynchronous reset while VRUN is at chunk 2.
        apply(1, 3'd5, 3'd1, 4'd1, 0, 0, mk(0,1,0,0,3'd1,1,0,0,0,0,0,0,1), "rst_seq_c0");
        apply(1, 3'd0, 3'd0, 4'd0, 0, 0, mk(0,1,0,0,3'd1,1,0,0,0,0,0,1,1), "rst_seq_c1");
        InstrValid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_stuck", 32'(Stuck), 0);
        check_val("rst_mid_chunk", 32'(ChunkIdx), 0);
        check_val("rst_mid_regwrite", 32'(RegWrite), 0);
        remaining = 0; l_op = '0; l_func = '0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // VALU Func=011 (Rd=15 must not redirect): four chunks, decode inputs ignored meanwhile.
        apply(1, 3'd5, 3'd3, 4'd15, 0, 0, mk(0,1,0,0,3'd3,1,0,0,0,0,0,0,1), "valu_c0");
        check("one_chunk_valu", act1, mk(0,1,0,0,3'd3,1,0,0,0,0,0,0,0));
        apply(1, 3'd4, 3'd7, 4'd15, 0, 0, mk(0,1,0,0,3'd3,1,0,0,0,0,0,1,1), "valu_c1");
        check("one_chunk_next", act1, mk(1,0,0,0,3'd0,0,1,1,0,2,1,0,0));
        apply(1, 3'd4, 3'd7, 4'd15, 0, 0, mk(0,1,0,0,3'd3,1,0,0,0,0,0,2,1), "valu_c2");
        apply(1, 3'd4, 3'd7, 4'd15, 0, 0, mk(0,1,0,0,3'd3,1,0,0,0,0,0,3,0), "valu_c3");
        apply(0, 3'd0, 3'd0, 4'd0,  0, 0, mk(0,0,0,0,3'd0,0,0,0,0,0,0,0,0), "valu_idle");
`ifdef VCU_PERF_CNT_EN
        check_val("perf_stall", StallCycles, 3);
        check_val("perf_vec", VecInstrs, 1);
`endif

        // VSTR with Hold on the second cycle: chunk 1 repeats, five cycles total.
        apply(1, 3'd7, 3'd0, 4'd2, 0, 0, mk(0,0,0,1,3'd0,1,0,1,0,1,2,0,1), "vstr_c0");
        apply(0, 3'd0, 3'd0, 4'd0, 1, 0, mk(0,0,0,0,3'd0,1,0,1,0,1,2,1,1), "vstr_hold");
        apply(0, 3'd0, 3'd0, 4'd0, 0, 0, mk(0,0,0,1,3'd0,1,0,1,0,1,2,1,1), "vstr_c1");
        apply(0, 3'd0, 3'd0, 4'd0, 0, 0, mk(0,0,0,1,3'd0,1,0,1,0,1,2,2,1), "vstr_c2");
        apply(0, 3'd0, 3'd0, 4'd0, 0, 0, mk(0,0,0,1,3'd0,1,0,1,0,1,2,3,0), "vstr_c3");
        apply(0, 3'd0, 3'd0, 4'd0, 0, 0, mk(0,0,0,0,3'd0,0,0,0,0,0,0,0,0), "vstr_idle");

        // VLDR flushed on its third cycle, then a scalar ALU op issues at once.
        apply(1, 3'd6, 3'd5, 4'd6, 0, 0, mk(0,1,1,0,3'd0,1,0,1,0,1,0,0,1), "vldr_c0");
        apply(0, 3'd0, 3'd0, 4'd0, 0, 0, mk(0,1,1,0,3'd0,1,0,1,0,1,0,1,1), "vldr_c1");
        apply(0, 3'd0, 3'd0, 4'd0, 0, 1, mk(0,0,1,0,3'd0,1,0,1,0,1,0,2,1), "vldr_flush");
        apply(1, 3'd0, 3'd1, 4'd7, 0, 0, mk(0,1,0,0,3'd1,0,0,0,3,0,0,0,0), "alu_after_flush");

        // Random traffic against the behavioural model.
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 9) != 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15)),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
            @(negedge clk);
            check($sformatf("rand_%0d", i), act0, model_expect());
            @(posedge clk);
            model_step();
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
